// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - sequential ALU with iterative shifter; define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter
module alu_seq_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [3:0]             alu_operation_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic [DATA_WIDTH-1:0]  b_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  alu_data_o,
    output logic                   zero_o,
    output logic                   invalid_op_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_LUI = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1000;

    logic [1:0]             state_q, state_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   shift_left_q, shift_left_d;
    logic [DATA_WIDTH-1:0]  alu_data_q, alu_data_d;
    logic                   zero_q, zero_d;
    logic                   invalid_op_q, invalid_op_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_left_d = shift_left_q;
        alu_data_d   = alu_data_q;
        invalid_op_d = invalid_op_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_DONE;
                    invalid_op_d = 1'b0;
                    cnt_d        = '0;
                    case (alu_operation_i)
                        OP_ADD: alu_data_d = a_i + b_i;
                        OP_SUB: alu_data_d = a_i - b_i;
                        OP_OR:  alu_data_d = a_i | b_i;
                        OP_AND: alu_data_d = a_i & b_i;
                        OP_NOR: alu_data_d = ~(a_i | b_i);
                        OP_LUI: alu_data_d = b_i << 16;
                        OP_SLL, OP_SRL: begin
`ifdef ALU_FAST_SHIFT_EN
                            alu_data_d = (alu_operation_i == OP_SLL) ? (b_i << shamt_i)
                                                                     : (b_i >> shamt_i);
`else
                            // B is loaded into the result register and shifted in place
                            alu_data_d   = b_i;
                            shift_left_d = (alu_operation_i == OP_SLL);
                            if (shamt_i != '0) begin
                                cnt_d   = shamt_i;
                                state_d = ST_SHIFT;
                            end
`endif
                        end
                        default: begin
                            alu_data_d   = '0;
                            invalid_op_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                alu_data_d = shift_left_q ? (alu_data_q << 1) : (alu_data_q >> 1);
                cnt_d      = cnt_q - SHAMT_WIDTH'(1);
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        zero_d = (alu_data_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_left_q <= 1'b0;
            alu_data_q   <= '0;
            zero_q       <= 1'b1;
            invalid_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_left_q <= shift_left_d;
            alu_data_q   <= alu_data_d;
            zero_q       <= zero_d;
            invalid_op_q <= invalid_op_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign alu_data_o   = alu_data_q;
    assign zero_o       = zero_q;
    assign invalid_op_o = invalid_op_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - randomized self-checking bench for alu_seq_exec against an arithmetic reference model
module tb_alu_seq_exec;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [3:0]  alu_operation_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [4:0]  shamt_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] alu_data_o;
    logic        zero_o;
    logic        invalid_op_o;

    int n_checks = 0;
    int n_fails  = 0;

    alu_seq_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .alu_operation_i(alu_operation_i),
        .a_i            (a_i),
        .b_i            (b_i),
        .shamt_i        (shamt_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .alu_data_o     (alu_data_o),
        .zero_o         (zero_o),
        .invalid_op_o   (invalid_op_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output logic inv,
                                  output int lat);
        inv = 1'b0;
        lat = 1;
        case (op)
            4'd3: r = a + b;
            4'd4: r = a - b;
            4'd1: r = a | b;
            4'd7: r = a & b;
            4'd8: r = ~(a | b);
            4'd6: r = {b[15:0], 16'h0000};
            4'd2: begin r = b << sh; lat = int'(sh) + 1; end
            4'd5: begin r = b >> sh; lat = int'(sh) + 1; end
            default: begin r = 32'h0; inv = 1'b1; end
        endcase
`ifdef ALU_FAST_SHIFT_EN
        lat = 1;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input bit hold_start);
        logic [31:0] exp_r;
        logic        exp_inv;
        int          exp_lat;
        int          cycles;
        bit          seen;
        bit          busy_ok;
        model(op, a, b, sh, exp_r, exp_inv, exp_lat);
        alu_operation_i = op;
        a_i             = a;
        b_i             = b;
        shamt_i         = sh;
        start_i         = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start_i = 1'b0;
        alu_operation_i = 4'($urandom);
        a_i             = $urandom;
        b_i             = $urandom;
        shamt_i         = 5'($urandom);
        cycles  = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (!busy_o) busy_ok = 1'b0;
            if (done_o) seen = 1'b1;
        end
        start_i = 1'b0;
        check_eq({name, ".latency"}, 64'(cycles), 64'(exp_lat));
        check_eq({name, ".busy"}, 64'(busy_ok), 64'd1);
        check_eq({name, ".data"}, 64'(alu_data_o), 64'(exp_r));
        check_eq({name, ".zero"}, 64'(zero_o), 64'(exp_r == 32'h0));
        check_eq({name, ".invalid"}, 64'(invalid_op_o), 64'(exp_inv));
        @(negedge clk);
        check_eq({name, ".done_pulse"}, 64'(done_o), 64'd0);
        check_eq({name, ".idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [4:0]  sh;
        bit          seen_done;
        reset           = 1'b0;
        start_i         = 1'b0;
        alu_operation_i = 4'h0;
        a_i             = 32'h0;
        b_i             = 32'h0;
        shamt_i         = 5'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst.busy", 64'(busy_o), 64'd0);
        check_eq("rst.done", 64'(done_o), 64'd0);
        check_eq("rst.data", 64'(alu_data_o), 64'd0);
        check_eq("rst.zero", 64'(zero_o), 64'd1);
        check_eq("rst.invalid", 64'(invalid_op_o), 64'd0);

        // First start is presented together with reset release.
        reset = 1'b1;
        run_op("add_wrap", 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
        run_op("sll_3_4", 4'b0010, 32'h1234_5678, 32'h0000_0003, 5'd4, 1'b0);
        run_op("srl_held", 4'b0101, 32'h0, 32'h8000_0000, 5'd31, 1'b1);
        run_op("lui", 4'b0110, 32'hDEAD_BEEF, 32'h0000_1234, 5'd7, 1'b0);
        run_op("inval_1001", 4'b1001, 32'h1, 32'h2, 5'd0, 1'b0);
        run_op("sll_sh0", 4'b0010, 32'h0, 32'hA5A5_0F0F, 5'd0, 1'b0);
        run_op("sub_wrap", 4'b0100, 32'h0, 32'h1, 5'd0, 1'b0);

        alu_operation_i = 4'b0010;
        b_i             = 32'h0000_0001;
        shamt_i         = 5'd20;
        start_i         = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("midrst.busy", 64'(busy_o), 64'd0);
        check_eq("midrst.done", 64'(done_o), 64'd0);
        check_eq("midrst.data", 64'(alu_data_o), 64'd0);
        check_eq("midrst.zero", 64'(zero_o), 64'd1);
        check_eq("midrst.invalid", 64'(invalid_op_o), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done_o || busy_o) seen_done = 1'b1;
        end
        check_eq("midrst.no_done", 64'(seen_done), 64'd0);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_op("rand", op, $urandom, $urandom, sh, bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter SHAMT_WIDTH, default 5, shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  request to execute one operation.
REQ-006 SHALL have port alu_operation_i  input  4  operation code from the ALU control stage.
REQ-007 SHALL have port a_i  input  DATA_WIDTH  operand A (rs).
REQ-008 SHALL have port b_i  input  DATA_WIDTH  operand B (rt or immediate).
REQ-009 SHALL have port shamt_i  input  SHAMT_WIDTH  shift amount.
REQ-010 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port alu_data_o  output  DATA_WIDTH  registered result, held until next accepted start.
REQ-013 SHALL have port zero_o  output  1  registered (alu_data_o == 0), updated with result.
REQ-014 SHALL have port invalid_op_o  output  1  registered, high when last accepted code was unsupported.

Function
REQ-015 SHALL decode: 0011 A+B; 0100 A-B; 0001 A|B; 0111 A&B; 1000 ~(A|B); 0110 {B[15:0],16'b0}; 0010 B<<shamt; 0101 B>>shamt (logical); every other code invalid.
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 SHALL accept start_i only in IDLE; start_i in SHIFT or DONE ignored, no queuing.
REQ-018 On accept SHALL latch code, A, B, shamt; later input changes have no effect on the operation.
REQ-019 Non-shift valid ops: IDLE->DONE, result registered at accept edge; done_o high the next cycle (latency 1).
REQ-020 Invalid code: IDLE->DONE, alu_data_o=0, zero_o=1, invalid_op_o=1, latency 1.
REQ-021 Shift with shamt=0: IDLE->DONE, result = B, latency 1.
REQ-022 Shift with shamt=N>0: IDLE->SHIFT, counter loaded with N, one bit shifted per cycle, counter decremented; SHIFT->DONE on the cycle the counter reaches 0; done_o high N+1 cycles after accept.
REQ-023 DONE SHALL last exactly one cycle, then IDLE; back-to-back start accepted the cycle after done_o.
REQ-024 Add/sub SHALL wrap modulo 2^DATA_WIDTH; no overflow flag.
REQ-025 invalid_op_o SHALL be cleared on acceptance of a valid code.
REQ-026 alu_data_o SHALL not show intermediate shift values to consumers as valid; they are qualified only by done_o.

Reset
REQ-027 reset low SHALL immediately force state IDLE, counter 0, busy_o=0, done_o=0, alu_data_o=0, zero_o=1, invalid_op_o=0.
REQ-028 Reset asserted mid-SHIFT SHALL abort the operation with no done_o pulse.
REQ-029 First start_i SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro ALU_FAST_SHIFT_EN defined: shifts use a combinational barrel shifter, all ops take the REQ-019 path (latency 1), SHIFT state unreachable.
REQ-031 Macro ALU_FAST_SHIFT_EN undefined: iterative shifting per REQ-022.

Verification
REQ-032 Reset mid-SHIFT (sll, shamt=20, reset after 5 cycles) -> outputs at reset values, no done_o.
REQ-033 add A=0xFFFFFFFF, B=0x00000001 -> done_o 1 cycle later, alu_data_o=0, zero_o=1.
REQ-034 sll B=0x00000003, shamt=4 -> done_o 5 cycles after accept, alu_data_o=0x00000030; with ALU_FAST_SHIFT_EN, 1 cycle.
REQ-035 srl B=0x80000000, shamt=31, start_i held high throughout -> single done_o after 32 cycles, alu_data_o=0x00000001, extra starts ignored until IDLE.
REQ-036 lui B=0x00001234 then code 1001 -> first 0x12340000, invalid_op_o=0; second alu_data_o=0, invalid_op_o=1.
